// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and helpers for the CNN layer result path
//
// Purpose : collector FSM state encoding, default word width, and the ReLU /
//           signed max helpers reused by the pooling stages.
// Ports   : none (package).
package cnn_pkg;

  localparam int CNN_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REDUCE  = 2'd2,
    ST_DRAIN   = 2'd3
  } coll_state_e;

  // Negative words (sign bit set, including the most negative value) clamp to 0.
  function automatic logic [CNN_DATA_W-1:0] relu(input logic [CNN_DATA_W-1:0] x);
    return x[CNN_DATA_W-1] ? '0 : x;
  endfunction

  function automatic logic [CNN_DATA_W-1:0] max2(input logic [CNN_DATA_W-1:0] a,
                                                 input logic [CNN_DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/cnn_relu_slot.sv
// rtl/cnn_relu_slot.sv - per-thread finish edge detect, capture gating and ReLU buffer
//
// Purpose : watches one layer thread's finished level; on its rising edge while
//           collecting (and not yet captured) stores ReLU of its words.
// Ports   : clk_i/rst_ni      clock, async active-low reset
//           clear_i           drop the captured flag (new collection)
//           collect_i         high while the collector is in COLLECT
//           finished_i        thread done level
//           words_i           N_WEIGHTS raw words, word w at [w*DATA_W +: DATA_W]
//           capture_o         capture happening this cycle
//           captured_o        registered captured flag
//           words_o           buffered ReLU words, same layout as words_i
module cnn_relu_slot
  import cnn_pkg::*;
#(
  parameter int N_WEIGHTS = 2,
  parameter int DATA_W    = CNN_DATA_W
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          collect_i,
  input  logic                          finished_i,
  input  logic [N_WEIGHTS*DATA_W-1:0]   words_i,
  output logic                          capture_o,
  output logic                          captured_o,
  output logic [N_WEIGHTS*DATA_W-1:0]   words_o
);

  logic                        fin_q;
  logic                        captured_q;
  logic [N_WEIGHTS*DATA_W-1:0] buf_q;

  // A clear in the same cycle wins so a restart never inherits a stale capture.
  assign capture_o  = collect_i & ~clear_i & finished_i & ~fin_q & ~captured_q;
  assign captured_o = captured_q;
  assign words_o    = buf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fin_q      <= 1'b0;
      captured_q <= 1'b0;
      buf_q      <= '0;
    end else begin
      fin_q <= finished_i;
      if (clear_i) begin
        captured_q <= 1'b0;
      end else if (capture_o) begin
        captured_q <= 1'b1;
      end
      if (capture_o) begin
        for (int w = 0; w < N_WEIGHTS; w++) begin
          buf_q[w*DATA_W +: DATA_W] <= relu(words_i[w*DATA_W +: DATA_W]);
        end
      end
    end
  end

endmodule

// File: rtl/cnn_layer_result_collector.sv
// rtl/cnn_layer_result_collector.sv - collects, ReLUs and pair-max-pools CNN layer outputs
//
// Purpose : captures each thread's words on its finish edge, max-pools thread
//           pairs per weight and streams the pooled words on a valid/ready port.
// Ports   : clk_i/rst_ni      clock, async active-low reset
//           start_i           begin or restart a collection
//           finished_i        per-thread done levels
//           layer_data_i      word (t,w) at [(t*N_WEIGHTS+w)*DATA_W +: DATA_W]
//           m_valid_o/m_ready_i/m_data_o/m_idx_o/m_last_o  pooled word stream
//           busy_o            not idle
//           done_o            one-cycle pulse after the final handshake
//           err_timeout_o     sticky collection timeout, cleared by start
module cnn_layer_result_collector
  import cnn_pkg::*;
#(
  parameter int N_THREADS = 4,
  parameter int N_WEIGHTS = 2,
  parameter int DATA_W    = CNN_DATA_W,
  parameter int TIMEOUT   = 2048,
  localparam int N_POOL   = N_THREADS / 2 * N_WEIGHTS,
  localparam int IDX_W    = (N_POOL > 1) ? $clog2(N_POOL) : 1,
  localparam int CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  start_i,
  input  logic [N_THREADS-1:0]                  finished_i,
  input  logic [N_THREADS*N_WEIGHTS*DATA_W-1:0] layer_data_i,
  output logic                                  m_valid_o,
  input  logic                                  m_ready_i,
  output logic [DATA_W-1:0]                     m_data_o,
  output logic [IDX_W-1:0]                      m_idx_o,
  output logic                                  m_last_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  err_timeout_o
);

  localparam int SLOT_W = N_WEIGHTS * DATA_W;

  coll_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             clear;
  logic [N_THREADS-1:0] capture, captured;
  logic [N_THREADS*SLOT_W-1:0] buf_all;
  logic [DATA_W-1:0] pool_q [N_POOL];
  logic             drain, mask_full;

  for (genvar t = 0; t < N_THREADS; t++) begin : g_slot
    cnn_relu_slot #(.N_WEIGHTS(N_WEIGHTS), .DATA_W(DATA_W)) u_slot (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear),
      .collect_i  (state_q == ST_COLLECT),
      .finished_i (finished_i[t]),
      .words_i    (layer_data_i[t*SLOT_W +: SLOT_W]),
      .capture_o  (capture[t]),
      .captured_o (captured[t]),
      .words_o    (buf_all[t*SLOT_W +: SLOT_W])
    );
  end

  // Including this cycle's captures lets REDUCE follow the last capture directly;
  // the buffers are written on the same edge, so REDUCE sees them settled.
  assign mask_full = &(captured | capture);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_COLLECT;
          clear   = 1'b1;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_COLLECT: begin
        if (mask_full) begin
          state_d = ST_REDUCE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REDUCE: begin
        state_d = ST_DRAIN;
        idx_d   = '0;
      end
      ST_DRAIN: begin
        if (m_ready_i) begin
          if (idx_q == IDX_W'(N_POOL - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Restart from any active state discards the partial frame and any done.
    if (start_i && state_q != ST_IDLE) begin
      state_d = ST_COLLECT;
      clear   = 1'b1;
      cnt_d   = '0;
      err_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_POOL; i++) pool_q[i] <= '0;
    end else if (state_q == ST_REDUCE) begin
      for (int p = 0; p < N_THREADS / 2; p++) begin
        for (int w = 0; w < N_WEIGHTS; w++) begin
          pool_q[p*N_WEIGHTS + w] <= max2(buf_all[((2*p)*N_WEIGHTS + w)*DATA_W +: DATA_W],
                                          buf_all[((2*p+1)*N_WEIGHTS + w)*DATA_W +: DATA_W]);
        end
      end
    end
  end

  assign drain         = (state_q == ST_DRAIN);
  assign m_valid_o     = drain;
  assign m_data_o      = drain ? pool_q[idx_q] : '0;
  assign m_idx_o       = drain ? idx_q : '0;
  assign m_last_o      = drain && (idx_q == IDX_W'(N_POOL - 1));
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_q;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_cnn_layer_result_collector.sv
// tb/tb_cnn_layer_result_collector.sv - scoreboard bench for cnn_layer_result_collector
module tb_cnn_layer_result_collector;

  localparam int NT = 4;
  localparam int NW = 2;
  localparam int DW = 16;
  localparam int TO = 64;
  localparam int NP = NT / 2 * NW;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [NT-1:0]       finished = '0;
  logic [NT*NW*DW-1:0] layer_data = '0;
  logic                m_ready = 1'b0;
  logic                m_valid;
  logic [DW-1:0]       m_data;
  logic [1:0]          m_idx;
  logic                m_last;
  logic                busy;
  logic                done;
  logic                err;

  always #5 clk = ~clk;

  cnn_layer_result_collector #(
    .N_THREADS(NT), .N_WEIGHTS(NW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .finished_i(finished),
    .layer_data_i(layer_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_data_o(m_data), .m_idx_o(m_idx), .m_last_o(m_last), .busy_o(busy),
    .done_o(done), .err_timeout_o(err)
  );

  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   hs_cnt = 0;
  int   done_cnt = 0;
  int   ready_mode = 0;
  int   cyc = 0;
  int   wv[NT][NW];

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int relu_m(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int max_m(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Ready driver: 0 always, 1 random, 2 pattern 1,0,0, other held low.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      case (ready_mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'($urandom_range(0, 1));
        2: m_ready = (cyc % 3 == 0);
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks stall stability and done.
  initial begin
    exp_t        e;
    bit          prev_stall;
    bit          exp_done;
    logic [DW-1:0] prev_data;
    logic [1:0]  prev_idx;
    prev_stall = 0;
    exp_done   = 0;
    prev_data  = '0;
    prev_idx   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
        exp_done   = 0;
      end else begin
        chk("done_pulse", int'(done), int'(exp_done));
        if (done) done_cnt++;
        exp_done = 0;
        if (prev_stall && m_valid) begin
          chk("stall_data", int'(m_data), int'(prev_data));
          chk("stall_idx", int'(m_idx), int'(prev_idx));
        end
        if (m_valid && m_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("m_data", int'($signed(m_data)), e.data);
            chk("m_idx", int'(m_idx), e.idx);
            chk("m_last", int'(m_last), int'(e.last));
            if (e.last) exp_done = 1;
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_idx   = m_idx;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_data();
    for (int t = 0; t < NT; t++)
      for (int w = 0; w < NW; w++)
        layer_data[(t*NW+w)*DW +: DW] = 16'(wv[t][w]);
  endtask

  task automatic push_expected();
    exp_t e;
    for (int p = 0; p < NT / 2; p++) begin
      for (int w = 0; w < NW; w++) begin
        e.data = max_m(relu_m(wv[2*p][w]), relu_m(wv[2*p+1][w]));
        e.idx  = p * NW + w;
        e.last = (p * NW + w == NP - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic randomize_words();
    for (int t = 0; t < NT; t++) begin
      for (int w = 0; w < NW; w++) begin
        case ($urandom_range(0, 7))
          0: wv[t][w] = -32768;
          1: wv[t][w] = 32767;
          2: wv[t][w] = 0;
          default: wv[t][w] = int'($urandom_range(0, 65535)) - 32768;
        endcase
      end
    end
  endtask

  task automatic pulse_start();
    step();
    finished = '0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < budget) begin
      step();
      n++;
    end
    chk("done_within_budget", int'(done_cnt != base), 1);
    step();
  endtask

  task automatic run_frame(input int gap_max);
    int ord[NT];
    int j;
    int tmp;
    int base_hs;
    base_hs = hs_cnt;
    load_data();
    pulse_start();
    for (int i = 0; i < NT; i++) ord[i] = i;
    for (int i = NT - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
    end
    for (int k = 0; k < NT; k++) begin
      if (k > 0) repeat ($urandom_range(0, gap_max)) step();
      if (k == NT - 1) push_expected();
      finished[ord[k]] = 1'b1;
    end
    step();
    for (int i = 0; i < NT * NW * DW / 32; i++) layer_data[i*32 +: 32] = $urandom;
    wait_done(300);
    chk("frame_handshakes", hs_cnt - base_hs, NP);
  endtask

  initial begin
    int c;
    int base_hs;
    int n;
    int sched_t[4];
    int sched_c[4];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_m_idx", int'(m_idx), 0);
    chk("rst_m_last", int'(m_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    step();

    // 1: all finish together
    wv[0][0] = 5;  wv[0][1] = -3;
    wv[1][0] = 2;  wv[1][1] = 7;
    wv[2][0] = -1; wv[2][1] = -9;
    wv[3][0] = 4;  wv[3][1] = 0;
    ready_mode = 0;
    run_frame(0);

    // 2: staggered T3,T0,T2,T1 at cycles 10,20,30,40
    sched_t[0] = 3; sched_t[1] = 0; sched_t[2] = 2; sched_t[3] = 1;
    sched_c[0] = 10; sched_c[1] = 20; sched_c[2] = 30; sched_c[3] = 40;
    load_data();
    pulse_start();
    c = 1;
    for (int k = 0; k < 4; k++) begin
      while (c < sched_c[k]) begin
        step();
        c++;
        chk("t2_no_early_valid", int'(m_valid), 0);
      end
      if (k == 3) push_expected();
      finished[sched_t[k]] = 1'b1;
    end
    step();
    chk("t2_reduce_valid_low", int'(m_valid), 0);
    chk("t2_reduce_busy", int'(busy), 1);
    step();
    chk("t2_first_valid", int'(m_valid), 1);
    chk("t2_first_idx", int'(m_idx), 0);
    wait_done(100);

    // 3: stalled drain, m_ready 1,0,0 pattern
    ready_mode = 2;
    run_frame(3);

    // 4: timeout with only T0..T2 finishing
    ready_mode = 0;
    randomize_words();
    load_data();
    pulse_start();
    finished = 4'b0111;
    for (int i = 0; i < TO - 1; i++) begin
      step();
      chk("t4_no_valid", int'(m_valid), 0);
    end
    chk("t4_err_before", int'(err), 0);
    chk("t4_busy_before", int'(busy), 1);
    step();
    chk("t4_err_set", int'(err), 1);
    chk("t4_idle_after", int'(busy), 0);
    chk("t4_valid_after", int'(m_valid), 0);
    repeat (5) step();
    chk("t4_err_sticky", int'(err), 1);
    pulse_start();
    chk("t4_err_cleared", int'(err), 0);
    push_expected();
    finished = 4'hF;
    wait_done(100);

    // 5: restart during DRAIN after 2 words
    randomize_words();
    load_data();
    pulse_start();
    push_expected();
    base_hs = hs_cnt;
    finished = 4'hF;
    n = 0;
    while (hs_cnt < base_hs + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_two_words", hs_cnt - base_hs, 2);
    step();
    start = 1'b1;
    finished = '0;
    ready_mode = 3;
    step();
    start = 1'b0;
    exp_q.delete();
    chk("t5_valid_dropped", int'(m_valid), 0);
    chk("t5_busy_collect", int'(busy), 1);
    repeat (3) step();
    chk("t5_no_done", int'(done), 0);
    ready_mode = 0;
    randomize_words();
    load_data();
    base_hs = hs_cnt;
    push_expected();
    finished = 4'hF;
    wait_done(100);
    chk("t5_fresh_handshakes", hs_cnt - base_hs, NP);

    // 6: asynchronous reset mid-DRAIN, then 16'h8000 captured as 0
    ready_mode = 3;
    randomize_words();
    load_data();
    pulse_start();
    push_expected();
    finished = 4'hF;
    repeat (3) step();
    chk("t6_in_drain", int'(m_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", int'(m_valid), 0);
    chk("t6_async_data", int'(m_data), 0);
    chk("t6_async_idx", int'(m_idx), 0);
    chk("t6_async_last", int'(m_last), 0);
    chk("t6_async_busy", int'(busy), 0);
    chk("t6_async_done", int'(done), 0);
    chk("t6_async_err", int'(err), 0);
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    ready_mode = 0;
    randomize_words();
    wv[0][0] = -32768; wv[0][1] = -32768;
    wv[1][0] = -5;     wv[1][1] = 3;
    run_frame(2);

    // Randomized frames with mixed readiness and arrival order
    for (int i = 0; i < 8; i++) begin
      ready_mode = int'($urandom_range(0, 2));
      randomize_words();
      run_frame(int'($urandom_range(0, 8)));
    end

    repeat (5) step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
